// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: instruction bit indices,
// FSM states, PC-source selects, exception causes and instruction class masks.
package cpu_pkg;

   localparam int NUM_INSTR_DEF = 54;
   typedef logic [NUM_INSTR_DEF-1:0] code_t;

   localparam int I_ADD   = 0,  I_ADDU  = 1,  I_SUB   = 2,  I_SUBU  = 3,  I_AND   = 4;
   localparam int I_OR    = 5,  I_XOR   = 6,  I_NOR   = 7,  I_SLT   = 8,  I_SLTU  = 9;
   localparam int I_SLL   = 10, I_SRL   = 11, I_SRA   = 12, I_SLLV  = 13, I_SRLV  = 14;
   localparam int I_SRAV  = 15, I_JR    = 16, I_ADDI  = 17, I_ADDIU = 18, I_ANDI  = 19;
   localparam int I_ORI   = 20, I_XORI  = 21, I_LW    = 22, I_SW    = 23, I_BEQ   = 24;
   localparam int I_BNE   = 25, I_SLTI  = 26, I_SLTIU = 27, I_LUI   = 28, I_J     = 29;
   localparam int I_JAL   = 30, I_CLZ   = 31, I_DIVU  = 32, I_ERET  = 33, I_JALR  = 34;
   localparam int I_LB    = 35, I_LBU   = 36, I_LHU   = 37, I_SB    = 38, I_SH    = 39;
   localparam int I_LH    = 40, I_C0    = 41, I_MFHI  = 42, I_MFLO  = 43, I_RSVD  = 44;
   localparam int I_MTHI  = 45, I_MTLO  = 46, I_MULT  = 47, I_MULTU = 48, I_SYSCALL = 49;
   localparam int I_TEQ   = 50, I_BGEZ  = 51, I_BREAK = 52, I_DIV   = 53;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EXE  = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_DIVW = 3'd5,
      S_EXC  = 3'd6
   } state_t;

   localparam logic [2:0] PCS_PC4 = 3'd0, PCS_BR = 3'd1, PCS_JMP = 3'd2;
   localparam logic [2:0] PCS_RS  = 3'd3, PCS_EXC = 3'd4, PCS_EPC = 3'd5;

   localparam logic [4:0] EXC_NONE  = 5'd0,  EXC_SYSCALL = 5'd8, EXC_BREAK = 5'd9;
   localparam logic [4:0] EXC_RI    = 5'd10, EXC_DIVTO   = 5'd12, EXC_TEQ = 5'd13;

   localparam logic [4:0] RS_MFC0 = 5'b00000, RS_MTC0 = 5'b00100;

   localparam code_t LOAD_MASK   = (code_t'(1) << I_LW) | (code_t'(1) << I_LB) | (code_t'(1) << I_LBU)
                                 | (code_t'(1) << I_LH) | (code_t'(1) << I_LHU);
   localparam code_t STORE_MASK  = (code_t'(1) << I_SW) | (code_t'(1) << I_SB) | (code_t'(1) << I_SH);
   localparam code_t BRANCH_MASK = (code_t'(1) << I_BEQ) | (code_t'(1) << I_BNE) | (code_t'(1) << I_BGEZ);
   localparam code_t JUMP_MASK   = (code_t'(1) << I_J) | (code_t'(1) << I_JR)
                                 | (code_t'(1) << I_JAL) | (code_t'(1) << I_JALR);
   localparam code_t LINK_MASK   = (code_t'(1) << I_JAL) | (code_t'(1) << I_JALR);
   localparam code_t HILO_MASK   = (code_t'(1) << I_MULT) | (code_t'(1) << I_MULTU)
                                 | (code_t'(1) << I_MTHI) | (code_t'(1) << I_MTLO);
   localparam code_t DIV_MASK    = (code_t'(1) << I_DIV) | (code_t'(1) << I_DIVU);
   localparam code_t TRAP_MASK   = (code_t'(1) << I_SYSCALL) | (code_t'(1) << I_BREAK)
                                 | (code_t'(1) << I_TEQ);

   // Exactly one bit set, and never the slot the decoder leaves unused.
   function automatic logic code_legal(input code_t c);
      return (c != '0) && ((c & (c - code_t'(1))) == '0) && !c[I_RSVD];
   endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_class_dec.sv
// Combinational instruction-class decode of the latched one-hot code.
// Zero latency; no flow control.
module ctrl_class_dec
   import cpu_pkg::*;
(
   input  code_t code_q,
   output logic  is_load,
   output logic  is_store,
   output logic  is_branch,
   output logic  is_jump,
   output logic  is_link,
   output logic  is_hilo,
   output logic  is_div,
   output logic  is_trap,
   output logic  is_cp0,
   output logic  illegal
);

   assign is_load   = |(code_q & LOAD_MASK);
   assign is_store  = |(code_q & STORE_MASK);
   assign is_branch = |(code_q & BRANCH_MASK);
   assign is_jump   = |(code_q & JUMP_MASK);
   assign is_link   = |(code_q & LINK_MASK);
   assign is_hilo   = |(code_q & HILO_MASK);
   assign is_div    = |(code_q & DIV_MASK);
   assign is_trap   = |(code_q & TRAP_MASK);
   assign is_cp0    = code_q[I_C0];
   assign illegal   = !code_legal(code_q);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer issuing per-cycle datapath enables.
// Outputs decoded from state and latched code; DIV waits on div_done with an optional watchdog.
module cpu_ctrl_fsm
   import cpu_pkg::*;
#(
   parameter int NUM_INSTR   = 54,
   parameter int DIV_TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_INSTR-1:0] code,
   input  logic [4:0]           rs_field,
   input  logic                 br_eq,
   input  logic                 rs_neg,
   input  logic                 div_done,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic [2:0]           pc_src,
   output logic                 rf_we,
   output logic                 dm_re,
   output logic                 dm_we,
   output logic                 hi_we,
   output logic                 lo_we,
   output logic                 div_start,
   output logic                 cp0_we,
   output logic                 eret,
   output logic                 exc_req,
   output logic [4:0]           exc_cause,
   output logic [2:0]           state_o
);

   localparam int CNT_W = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;

   state_t               state, state_d;
   logic [NUM_INSTR-1:0] code_q;
   logic [CNT_W-1:0]     div_cnt, div_cnt_d;
   logic [4:0]           cause_q, cause_d;
   logic                 is_load, is_store, is_branch, is_jump, is_link;
   logic                 is_hilo, is_div, is_trap, is_cp0, illegal;
   logic                 code_ok, br_taken, div_to;

   ctrl_class_dec u_class_dec (
      .code_q    (code_q),
      .is_load   (is_load),
      .is_store  (is_store),
      .is_branch (is_branch),
      .is_jump   (is_jump),
      .is_link   (is_link),
      .is_hilo   (is_hilo),
      .is_div    (is_div),
      .is_trap   (is_trap),
      .is_cp0    (is_cp0),
      .illegal   (illegal)
   );

   assign code_ok  = !$isunknown(code) && code_legal(code);
   assign br_taken = (code_q[I_BEQ] & br_eq) | (code_q[I_BNE] & !br_eq) | (code_q[I_BGEZ] & !rs_neg);
   assign div_to   = (DIV_TIMEOUT != 0) && (div_cnt == CNT_W'(DIV_TIMEOUT - 1));
   assign state_o  = rst ? 3'd0 : state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IF;
         code_q  <= '0;
         div_cnt <= '0;
         cause_q <= EXC_NONE;
      end else begin
         state   <= state_d;
         div_cnt <= div_cnt_d;
         cause_q <= cause_d;
         if (state == S_ID)
            code_q <= code;
      end
   end

   always_comb begin
      state_d   = state;
      div_cnt_d = div_cnt;
      cause_d   = cause_q;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = PCS_PC4;
      rf_we     = 1'b0;
      dm_re     = 1'b0;
      dm_we     = 1'b0;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      div_start = 1'b0;
      cp0_we    = 1'b0;
      eret      = 1'b0;
      exc_req   = 1'b0;
      exc_cause = EXC_NONE;

      case (state)
         S_IF: begin
            ir_we   = 1'b1;
            state_d = S_ID;
         end
         S_ID: begin
            if (code_ok) begin
               state_d = S_EXE;
            end else begin
               state_d = S_EXC;
               cause_d = EXC_RI;
            end
         end
         S_EXE: begin
            // Classes are mutually exclusive once the code has passed the ID check.
            if (illegal) begin
               state_d = S_EXC;
               cause_d = EXC_RI;
            end else if (is_load || is_store) begin
               state_d = S_MEM;
            end else if (is_branch) begin
               pc_we   = 1'b1;
               pc_src  = br_taken ? PCS_BR : PCS_PC4;
               state_d = S_IF;
            end else if (is_jump) begin
               pc_we   = 1'b1;
               pc_src  = (code_q[I_J] || code_q[I_JAL]) ? PCS_JMP : PCS_RS;
               rf_we   = is_link;
               state_d = S_IF;
            end else if (is_hilo) begin
               pc_we   = 1'b1;
               hi_we   = !code_q[I_MTLO];
               lo_we   = !code_q[I_MTHI];
               state_d = S_IF;
            end else if (is_div) begin
               div_start = 1'b1;
               div_cnt_d = '0;
               state_d   = S_DIVW;
            end else if (is_trap) begin
               if (code_q[I_TEQ] && !br_eq) begin
                  pc_we   = 1'b1;
                  state_d = S_IF;
               end else begin
                  state_d = S_EXC;
                  cause_d = code_q[I_SYSCALL] ? EXC_SYSCALL :
                            code_q[I_BREAK]   ? EXC_BREAK   : EXC_TEQ;
               end
            end else if (code_q[I_ERET]) begin
               eret    = 1'b1;
               pc_we   = 1'b1;
               pc_src  = PCS_EPC;
               state_d = S_IF;
            end else if (is_cp0) begin
               if (rs_field == RS_MFC0) begin
                  state_d = S_WB;
               end else if (rs_field == RS_MTC0) begin
                  cp0_we  = 1'b1;
                  pc_we   = 1'b1;
                  state_d = S_IF;
               end else begin
                  state_d = S_EXC;
                  cause_d = EXC_RI;
               end
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (is_load) begin
               dm_re   = 1'b1;
               state_d = S_WB;
            end else begin
               dm_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_IF;
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            pc_we   = 1'b1;
            dm_re   = is_load;
            state_d = S_IF;
         end
         S_DIVW: begin
            div_cnt_d = div_cnt + CNT_W'(1);
            if (div_done) begin
               hi_we   = 1'b1;
               lo_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_IF;
            end else if (div_to) begin
               state_d = S_EXC;
               cause_d = EXC_DIVTO;
            end
         end
         S_EXC: begin
            exc_req   = 1'b1;
            exc_cause = cause_q;
            pc_we     = 1'b1;
            pc_src    = PCS_EXC;
            state_d   = S_IF;
         end
         default: state_d = S_IF;
      endcase

      // Reset beats everything, including a divide in flight.
      if (rst) begin
         ir_we     = 1'b0;
         pc_we     = 1'b0;
         pc_src    = PCS_PC4;
         rf_we     = 1'b0;
         dm_re     = 1'b0;
         dm_we     = 1'b0;
         hi_we     = 1'b0;
         lo_we     = 1'b0;
         div_start = 1'b0;
         cp0_we    = 1'b0;
         eret      = 1'b0;
         exc_req   = 1'b0;
         exc_cause = EXC_NONE;
      end
   end

endmodule
